// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, command bytes and
// default bus timing in CLOCK_50 cycles.
package ps2_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 20;

  localparam int INHIBIT_CYCLES_DEF = 5000;
  localparam int START_TIMEOUT_DEF  = 750000;
  localparam int PACKET_TIMEOUT_DEF = 100000;

  localparam logic [DATA_W-1:0] CMD_SET_LEDS = 8'hED;
  localparam logic [DATA_W-1:0] CMD_RESET    = 8'hFF;
  localparam logic [DATA_W-1:0] CMD_ENABLE   = 8'hF4;
  localparam logic [DATA_W-1:0] RESP_ACK     = 8'hFA;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE,
    ERR
  } tx_state_t;

  // PS/2 frames carry odd parity: the bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus a falling-edge detector on
// the synced clock; shared by the host transmitter and the receive path.
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic ps2_clk_pin,
  input  logic ps2_dat_pin,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic clk_p0, clk_p1, clk_p2;
  logic dat_p0, dat_p1;

  // Idle bus level is high, so reset to 1 to avoid a false edge afterwards.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_pin;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= ps2_dat_pin;
      dat_p1 <= dat_p0;
    end
  end

  assign clk_sync = clk_p1;
  assign dat_sync = dat_p1;
  assign clk_fall = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, LSB-first data,
// odd parity, stop and device ACK, reporting done or error as one-cycle pulses.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int START_TIMEOUT  = START_TIMEOUT_DEF,
  parameter int PACKET_TIMEOUT = PACKET_TIMEOUT_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error,
  inout  wire               PS2_CLK,
  inout  wire               PS2_DAT
);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_TO = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] PKT_TO   = CNT_W'(PACKET_TIMEOUT);

  tx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shift;
  logic              par, tx_bit, bit_val;
  logic              load_cmd, load_bit;
  logic              clk_low, dat_low;
  logic              clk_sync, dat_sync, clk_fall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  ps2_line_sync u_sync (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .ps2_clk_pin (PS2_CLK),
    .ps2_dat_pin (PS2_DAT),
    .clk_sync    (clk_sync),
    .dat_sync    (dat_sync),
    .clk_fall    (clk_fall)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Payload registers are only read in states that follow their load.
  always_ff @(posedge CLOCK_50) begin
    if (load_cmd) begin
      shift <= cmd_data;
      par   <= odd_parity(cmd_data);
    end
    if (load_bit) tx_bit <= bit_val;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = sat_inc(cnt);
    bit_idx_nxt = bit_idx;
    load_cmd    = 1'b0;
    load_bit    = 1'b0;
    bit_val     = 1'b1;
    clk_low     = 1'b0;
    dat_low     = 1'b0;
    cmd_ready   = 1'b0;
    tx_busy     = 1'b1;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        tx_busy   = 1'b0;
        cnt_nxt   = '0;
        if (cmd_valid) begin
          load_cmd  = 1'b1;
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_low = 1'b1;
        if (cnt >= INH_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        dat_low = 1'b1;
        if (clk_fall) begin
          load_bit    = 1'b1;
          bit_val     = shift[0];
          bit_idx_nxt = 4'd1;
          cnt_nxt     = '0;
          state_nxt   = DATA;
        end else if (cnt >= START_TO) begin
          state_nxt = ERR;
        end
      end
      DATA: begin
        dat_low = ~tx_bit;
        if (cnt >= PKT_TO) begin
          state_nxt = ERR;
        end else if (clk_fall) begin
          load_bit = 1'b1;
          if (bit_idx == 4'(DATA_W)) begin
            bit_val   = par;
            state_nxt = PARITY;
          end else begin
            bit_val     = shift[bit_idx[2:0]];
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      PARITY: begin
        dat_low = ~tx_bit;
        if (cnt >= PKT_TO) state_nxt = ERR;
        else if (clk_fall) state_nxt = STOP;
      end
      STOP: begin
        if (cnt >= PKT_TO) state_nxt = ERR;
        else if (clk_fall) state_nxt = dat_sync ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (cnt >= PKT_TO) begin
          state_nxt = ERR;
        end else if (clk_sync && dat_sync) begin
          tx_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        tx_error  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule
